// File: rtl/alu_ctrl_if.sv
// Request/response channel between the instruction decoder and alu_ctrl.
//   req_*  : command channel (valid/ready), decoder -> controller
//   rsp_*  : response channel (valid/ready), controller -> consumer
//   flags  : {zero, negative, carry, overflow, parity} of the last legal command
interface alu_ctrl_if;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned FW = 5;

    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_cmd;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_wb;
    logic          rsp_err;
    logic [FW-1:0] flags;

    // Requester side: issues commands, consumes responses
    modport master (
        output req_valid, req_cmd, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_wb, rsp_err, flags
    );

    // Controller side
    modport slave (
        input  req_valid, req_cmd, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_wb, rsp_err, flags
    );
endinterface

// File: rtl/alu_ctrl.sv
// Command sequencer in front of an 8-bit combinational ALU.
// Native ops take one ALU cycle; MUL (8x8, low byte) is shift-and-add built
// from ALU SUM and LSL steps.
//   clk, rst_n           : clock, async active-low reset
//   bus (slave)          : request/response channel and registered flags
//   alu_a/alu_b/alu_op   : registered ALU drive
//   alu_out, alu_<flag>  : ALU result and flag outputs
module alu_ctrl #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_ctrl_if.slave  bus,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_out,
    input  logic       alu_zero,
    input  logic       alu_negative,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       alu_parity
);
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned FW = 5;
    localparam int unsigned NW = 4;

    localparam logic [CW-1:0] CMD_SUM = CW'(0);
    localparam logic [CW-1:0] CMD_SUB = CW'(1);
    localparam logic [CW-1:0] CMD_LSL = CW'(4);
    localparam logic [CW-1:0] CMD_NOT = CW'(6);
    localparam logic [CW-1:0] CMD_MUL = CW'(7);
    localparam logic [CW-1:0] CMD_CMP = CW'(8);
    localparam logic [NW-1:0] N_ITER  = NW'(8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL_ADD,
        S_MUL_SHL,
        S_DONE
    } state_e;

    state_e        state_q,   state_d;
    logic [CW-1:0] cmd_q,     cmd_d;
    logic [DW-1:0] a_q,       a_d;      // operand a, doubles as MUL multiplicand
    logic [DW-1:0] b_q,       b_d;      // operand b, doubles as MUL multiplier
    logic [DW-1:0] acc_q,     acc_d;
    logic [NW-1:0] cnt_q,     cnt_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_result_q, rsp_result_d;
    logic          rsp_wb_q,  rsp_wb_d;
    logic          rsp_err_q, rsp_err_d;
    logic [FW-1:0] flags_q,   flags_d;
    logic [DW-1:0] alu_a_q,   alu_a_d;
    logic [DW-1:0] alu_b_q,   alu_b_d;
    logic [CW-1:0] alu_op_q,  alu_op_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_wb_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            flags_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_wb_q     <= rsp_wb_d;
            rsp_err_q    <= rsp_err_d;
            flags_q      <= flags_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_wb_d     = rsp_wb_q;
        rsp_err_d    = rsp_err_q;
        flags_d      = flags_q;
        alu_a_d      = '0;
        alu_b_d      = '0;
        alu_op_d     = '0;

        case (state_q)
            S_IDLE: begin
                // req_ready is high throughout IDLE, so valid alone is an accept
                if (bus.req_valid) begin
                    cmd_d = bus.req_cmd;
                    a_d   = bus.req_a;
                    b_d   = bus.req_b;
                    acc_d = '0;
                    cnt_d = '0;
                    if (bus.req_cmd <= CMD_NOT || bus.req_cmd == CMD_CMP) begin
                        state_d = S_EXEC;
                    end else if (bus.req_cmd == CMD_MUL) begin
                        state_d = bus.req_b[0] ? S_MUL_ADD : S_MUL_SHL;
                    end else begin
                        state_d      = S_DONE;
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = '0;
                        rsp_wb_d     = 1'b0;
                        rsp_err_d    = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                state_d      = S_DONE;
                rsp_valid_d  = 1'b1;
                rsp_result_d = alu_out;
                rsp_wb_d     = (cmd_q != CMD_CMP);
                rsp_err_d    = 1'b0;
                flags_d      = {alu_zero, alu_negative, alu_carry, alu_overflow, alu_parity};
            end
            S_MUL_ADD: begin
                acc_d   = alu_out;
                state_d = S_MUL_SHL;
            end
            S_MUL_SHL: begin
                a_d   = alu_out;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + NW'(1);
                if (cnt_d == N_ITER || (EARLY_EXIT && b_d == '0)) begin
                    // The accumulator is final: no add follows the last shift
                    state_d      = S_DONE;
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = acc_q;
                    rsp_wb_d     = 1'b1;
                    rsp_err_d    = 1'b0;
                    flags_d      = {(acc_q == '0), acc_q[DW-1], 1'b0, 1'b0, ^acc_q};
                end else begin
                    state_d = b_d[0] ? S_MUL_ADD : S_MUL_SHL;
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // ALU drive is registered, so it is decoded from the state being entered
        case (state_d)
            S_EXEC: begin
                alu_op_d = (cmd_d == CMD_CMP) ? CMD_SUB : cmd_d;
                alu_a_d  = a_d;
                alu_b_d  = b_d;
            end
            S_MUL_ADD: begin
                alu_op_d = CMD_SUM;
                alu_a_d  = acc_d;
                alu_b_d  = a_d;
            end
            S_MUL_SHL: begin
                alu_op_d = CMD_LSL;
                alu_a_d  = a_d;
                alu_b_d  = DW'(1);
            end
            default: begin
                alu_op_d = '0;
                alu_a_d  = '0;
                alu_b_d  = '0;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_wb     = rsp_wb_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.flags      = flags_q;
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_op         = alu_op_q;
endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: two instances (EARLY_EXIT=0 and 1) each wired to a
// behavioural ALU; one shared stimulus port is steered to the selected instance.
module tb_alu_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_ctrl_if if0();
    alu_ctrl_if if1();

    logic       sel;
    logic       req_valid;
    logic       rsp_ready;
    logic [3:0] req_cmd;
    logic [7:0] req_a;
    logic [7:0] req_b;

    logic [7:0] alu_a   [2];
    logic [7:0] alu_b   [2];
    logic [3:0] alu_op  [2];
    logic [7:0] alu_out [2];
    logic [4:0] alu_fl  [2];

    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] exp_flags [2];

    // Behavioural ALU: {zero, negative, carry, overflow, parity, result}
    function automatic logic [12:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        logic       v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin w = 9'(a) + 9'(b); r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: begin r = a << b[2:0]; c = a[7]; end
            4'd5: begin r = a >> b[2:0]; c = a[0]; end
            4'd6: r = ~a;
            default: r = '0;
        endcase
        return {(r == 8'h00), r[7], c, v, ^r, r};
    endfunction

    assign {alu_fl[0], alu_out[0]} = alu_fn(alu_op[0], alu_a[0], alu_b[0]);
    assign {alu_fl[1], alu_out[1]} = alu_fn(alu_op[1], alu_a[1], alu_b[1]);

    assign if0.req_valid = req_valid & ~sel;
    assign if1.req_valid = req_valid &  sel;
    assign if0.rsp_ready = rsp_ready & ~sel;
    assign if1.rsp_ready = rsp_ready &  sel;
    assign if0.req_cmd = req_cmd;
    assign if1.req_cmd = req_cmd;
    assign if0.req_a   = req_a;
    assign if1.req_a   = req_a;
    assign if0.req_b   = req_b;
    assign if1.req_b   = req_b;

    alu_ctrl #(.EARLY_EXIT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_out(alu_out[0]),
        .alu_zero(alu_fl[0][4]), .alu_negative(alu_fl[0][3]), .alu_carry(alu_fl[0][2]),
        .alu_overflow(alu_fl[0][1]), .alu_parity(alu_fl[0][0])
    );

    alu_ctrl #(.EARLY_EXIT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_out(alu_out[1]),
        .alu_zero(alu_fl[1][4]), .alu_negative(alu_fl[1][3]), .alu_carry(alu_fl[1][2]),
        .alu_overflow(alu_fl[1][1]), .alu_parity(alu_fl[1][0])
    );

    logic       o_req_ready, o_valid, o_wb, o_err;
    logic [7:0] o_result, o_alu_a, o_alu_b;
    logic [3:0] o_alu_op;
    logic [4:0] o_flags;
    assign o_req_ready = sel ? if1.req_ready  : if0.req_ready;
    assign o_valid     = sel ? if1.rsp_valid  : if0.rsp_valid;
    assign o_result    = sel ? if1.rsp_result : if0.rsp_result;
    assign o_wb        = sel ? if1.rsp_wb     : if0.rsp_wb;
    assign o_err       = sel ? if1.rsp_err    : if0.rsp_err;
    assign o_flags     = sel ? if1.flags      : if0.flags;
    assign o_alu_a     = sel ? alu_a[1]  : alu_a[0];
    assign o_alu_b     = sel ? alu_b[1]  : alu_b[0];
    assign o_alu_op    = sel ? alu_op[1] : alu_op[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (dut%0d, t=%0t): got 0x%0h expected 0x%0h", tag, sel, $time, got, exp);
        end
    endtask

    // One command end to end; called at posedge+1 with the selected instance idle
    task automatic do_cmd(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b, input int dly);
        int         lat, exp_lat, pc, msb, s;
        logic [7:0] er;
        logic [4:0] ef;
        logic       ewb, eerr;
        logic [12:0] r;
        s = int'(sel);
        pc = 0;
        msb = -1;
        for (int i = 0; i < 8; i++) if (b[i]) begin pc++; msb = i; end
        if (cmd == 4'd7) begin
            er = 8'((int'(a) * int'(b)) % 256);
            ef = {(er == 8'h00), er[7], 1'b0, 1'b0, ^er};
            ewb = 1'b1; eerr = 1'b0;
            if (s == 0)      exp_lat = 8 + pc;
            else if (b == 0) exp_lat = 1;
            else             exp_lat = msb + 1 + pc;
        end else if (cmd <= 4'd8) begin
            r = alu_fn((cmd == 4'd8) ? 4'd1 : cmd, a, b);
            er = r[7:0]; ef = r[12:8];
            ewb = (cmd != 4'd8); eerr = 1'b0;
            exp_lat = 1;
        end else begin
            er = 8'h00; ef = exp_flags[s];
            ewb = 1'b0; eerr = 1'b1;
            exp_lat = 0;
        end

        req_cmd = cmd; req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = 1'b0;
        chk("req_ready_idle", 32'(o_req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = 8'($urandom); req_b = 8'($urandom); req_cmd = 4'($urandom);
        if (cmd <= 4'd6 || cmd == 4'd8) begin
            chk("exec_alu_op", 32'(o_alu_op), 32'((cmd == 4'd8) ? 4'd1 : cmd));
            chk("exec_alu_a", 32'(o_alu_a), 32'(a));
            chk("exec_alu_b", 32'(o_alu_b), 32'(b));
        end
        lat = 0;
        while (!o_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("result", 32'(o_result), 32'(er));
        chk("wb", 32'(o_wb), 32'(ewb));
        chk("err", 32'(o_err), 32'(eerr));
        chk("flags", 32'(o_flags), 32'(ef));
        chk("done_alu_op", 32'(o_alu_op), 32'd0);
        chk("done_req_ready", 32'(o_req_ready), 32'd0);
        exp_flags[s] = ef;

        for (int k = 0; k < dly; k++) begin
            if (k == 0) begin req_valid = 1'b1; req_cmd = 4'd0; end
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_result", 32'(o_result), 32'(er));
            chk("hold_flags", 32'(o_flags), 32'(ef));
            chk("hold_req_ready", 32'(o_req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("release_valid", 32'(o_valid), 32'd0);
        chk("release_req_ready", 32'(o_req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0;
        sel = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b0;
        req_cmd = '0; req_a = '0; req_b = '0;
        exp_flags[0] = '0; exp_flags[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(o_req_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_flags", 32'(o_flags), 32'd0);
        chk("rst_alu_op", 32'(o_alu_op), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases on the fixed-iteration instance
        sel = 1'b0;
        do_cmd(4'd0, 8'hFF, 8'h01, 0);
        do_cmd(4'd7, 8'd13, 8'd11, 1);
        do_cmd(4'd7, 8'd16, 8'd16, 0);
        do_cmd(4'd8, 8'h05, 8'h05, 0);
        do_cmd(4'd12, 8'h33, 8'h44, 2);
        do_cmd(4'd1, 8'h10, 8'h20, 5);
        do_cmd(4'd7, 8'hFF, 8'hFF, 0);
        do_cmd(4'd7, 8'hA5, 8'h00, 0);

        // Directed cases on the early-exit instance
        sel = 1'b1;
        do_cmd(4'd7, 8'd3, 8'd2, 0);
        do_cmd(4'd7, 8'd77, 8'd0, 1);
        do_cmd(4'd7, 8'hFF, 8'h80, 0);
        do_cmd(4'd7, 8'hFF, 8'hFF, 0);

        // Reset in the middle of a long MUL
        sel = 1'b0;
        req_cmd = 4'd7; req_a = 8'hFF; req_b = 8'hFF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(o_req_ready), 32'd1);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_result", 32'(o_result), 32'd0);
        chk("midrst_wb", 32'(o_wb), 32'd0);
        chk("midrst_err", 32'(o_err), 32'd0);
        chk("midrst_flags", 32'(o_flags), 32'd0);
        chk("midrst_alu_op", 32'(o_alu_op), 32'd0);
        chk("midrst_alu_a", 32'(o_alu_a), 32'd0);
        chk("midrst_alu_b", 32'(o_alu_b), 32'd0);
        exp_flags[0] = '0; exp_flags[1] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_cmd(4'd1, 8'h05, 8'h03, 0);

        // Randomized commands across both instances
        for (int n = 0; n < 240; n++) begin
            logic [3:0] c;
            sel = 1'($urandom_range(0, 1));
            c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) c = 4'd7;
            do_cmd(c, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
Command sequencer in front of the 8-bit combinational ALU. It accepts one command at a time over a valid/ready request channel and drives the ALU operand and op inputs. It returns the result, a registered 5-bit flag set and status over a valid/ready response channel. Native ALU ops take one cycle. MUL (8x8, low byte) is built from repeated ALU SUM and LSL steps. The block sits between the instruction decoder and the ALU instance.

Parameters:
EARLY_EXIT, 0, 1 = MUL stops iterating as soon as the remaining multiplier is 0; 0 = always exactly 8 iterations.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  command present
req_ready  output  1  controller can accept a command (high only in IDLE)
req_cmd  input  4  0 SUM, 1 SUB, 2 AND, 3 OR, 4 LSL, 5 LSR, 6 NOT, 7 MUL, 8 CMP, 9-15 illegal
req_a  input  8  operand a
req_b  input  8  operand b
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response
rsp_result  output  8  result byte
rsp_wb  output  1  result must be written back (0 for CMP and illegal commands)
rsp_err  output  1  illegal command
flags  output  5  {zero, negative, carry, overflow, parity}, registered
alu_a  output  8  to ALU a
alu_b  output  8  to ALU b
alu_op  output  4  to ALU op
alu_out  input  8  from ALU out
alu_zero, alu_negative, alu_carry, alu_overflow, alu_parity  input  1 each  ALU flag outputs

Behaviour:
- Reset (async, any state, including mid-MUL): state goes to IDLE. req_ready=1. rsp_valid, rsp_result, rsp_wb, rsp_err, flags, alu_a, alu_b, alu_op all 0. Any in-flight command is dropped.
- States: IDLE, EXEC, MUL_ADD, MUL_SHL, DONE.
- Accept edge: the edge where req_valid & req_ready. The controller latches cmd/a/b at that edge.
- IDLE transitions on accept:
  - cmd 0-6 or 8 -> EXEC.
  - cmd 7 -> MUL_ADD if b[0]=1, else MUL_SHL. mcand=a, mplier=b, acc=0, iteration count=0.
  - cmd 9-15 -> DONE with rsp_err=1, rsp_result=0, rsp_wb=0. flags are not updated.
- EXEC (1 cycle):
  - ALU drive: alu_op=cmd (CMP drives 1=SUB), alu_a=a, alu_b=b.
  - On the next edge: capture alu_out into rsp_result and the ALU flags into flags, then go to DONE.
  - rsp_wb=1 except for CMP.
  - Single-op latency: rsp_valid is high after accept edge +1.
- MUL_ADD:
  - ALU drive: op=SUM, a=acc, b=mcand; capture acc=alu_out.
  - Next state: MUL_SHL.
- MUL_SHL:
  - ALU drive: op=LSL, a=mcand, b=1; capture mcand=alu_out, shift mplier right by 1 internally, increment iteration count.
  - Exit to DONE when 8 iterations are complete, or when EXEC_EXIT=1 and the new mplier is 0.
  - Otherwise go to MUL_ADD if the new mplier[0]=1, else stay in MUL_SHL.
- MUL latency:
  - EARLY_EXIT=0: exactly 8+popcount(b) cycles; rsp_valid is high after accept edge +8+popcount(b).
  - EARLY_EXIT=1: (msb index of b +1)+popcount(b) cycles. b=0 finishes after 1 cycle with result 0.
- MUL result and flags: product mod 256. zero, negative and parity come from the final byte. carry=0, overflow=0. rsp_wb=1.
- Idle ALU drive: outside EXEC/MUL states, alu_op=0, alu_a=0, alu_b=0.
- DONE:
  - rsp_valid=1; rsp_result/rsp_wb/rsp_err/flags held stable while rsp_ready=0.
  - The edge with rsp_ready=1 returns to IDLE and clears rsp_valid.
  - req_ready is 0 in DONE: there is no overlap of a new request with a pending response.
- flags hold their value between commands; only a completed legal command updates them.
- req_* inputs are ignored outside IDLE. Operand changes after the accept edge have no effect.

Test Plan:
- SUM a=0xFF b=0x01 -> rsp_valid 1 cycle after accept; result 0x00; flags zero=1, carry=1, negative=0; rsp_wb=1.
- MUL a=13 b=11, EARLY_EXIT=0 -> exactly 11 cycles; result 0x8F; flags negative=1, parity=1, zero=0, carry=0, overflow=0. MUL 16*16 -> result 0x00, zero=1.
- MUL a=3 b=2, EARLY_EXIT=1 -> 3 cycles; result 0x06. MUL b=0 -> 1 cycle; result 0, zero=1.
- CMP a=0x05 b=0x05 -> flags zero=1; rsp_wb=0. Then cmd=12 -> rsp_err=1, result 0, flags still zero=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after SUB 0x10-0x20 -> result 0xF0 and negative=1 stable throughout; req_ready=0 throughout; a req_valid pulse in that window is not accepted.
- Assert rst_n=0 during cycle 4 of MUL 0xFF*0xFF -> immediately IDLE, all outputs 0. A following SUB 0x05-0x03 gives result 0x02 after 1 cycle.
